fft_hdmi_fifo_ctrl: RTL

FFT_HDMI_FIFO_CTRL -- requirements
Module: fft_hdmi_fifo_ctrl

---
 rtl/fft_hdmi_fifo_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fft_hdmi_fifo_ctrl.sv
// FFT-to-HDMI FIFO controller: frame-gated write side, line-based read side with zero-fill.
// Optional statistics counters are enabled with `define FFT_FIFO_CTRL_STATS_EN.
module fft_hdmi_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 512,
  parameter int unsigned LINE_LEN   = 512
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  fft_valid,
  input  logic [DATA_WIDTH-1:0] fft_data,
  input  logic                  fft_last,
  input  logic                  line_req,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   fifo_wr_water_level,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  line_done,
  output logic                  frame_drop,
  output logic                  underflow
`ifdef FFT_FIFO_CTRL_STATS_EN
  ,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           ufl_cnt,
  output logic [15:0]           ign_cnt
`endif
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_PASS = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_FILL = 2'd2;

  // A frame is only accepted if the whole frame is guaranteed to fit.
  localparam int unsigned ACCEPT_LVL = (1 << ADDR_WIDTH) - FRAME_LEN;
  localparam int unsigned LAST_PIX_INT = LINE_LEN - 1;
  localparam logic [ADDR_WIDTH:0] LAST_PIX = LAST_PIX_INT[ADDR_WIDTH:0];

  logic [1:0] w_state_q, w_state_d;
  logic [1:0] r_state_q, r_state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic wr_en;
  logic drop_d, ufl_d, ign_d;
  logic pv_d, ld_d;
  logic [DATA_WIDTH-1:0] pd_d;
  logic frame_ok, line_ok, rd_grant, cnt_last;

  assign frame_ok = 32'(fifo_wr_water_level) <= ACCEPT_LVL;
  assign line_ok  = 32'(fifo_rd_water_level) >= LINE_LEN;
  assign rd_grant = (r_state_q == R_READ) && !fifo_empty;
  assign cnt_last = (cnt_q == LAST_PIX);

  always_comb begin
    w_state_d = w_state_q;
    wr_en     = 1'b0;
    drop_d    = 1'b0;
    ovf_d     = ovf_q;
    case (w_state_q)
      W_IDLE: begin
        if (fft_valid) begin
          if (frame_ok) begin
            wr_en = 1'b1;
            if (!fft_last) w_state_d = W_PASS;
          end else begin
            drop_d = 1'b1;
            if (!fft_last) w_state_d = W_DROP;
          end
        end
      end
      W_PASS: begin
        if (fft_valid) begin
          wr_en = !fifo_full;
          if (fifo_full) ovf_d = 1'b1;
          if (fft_last) w_state_d = W_IDLE;
        end
      end
      W_DROP: begin
        if (fft_valid && fft_last) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Combinational write path is gated so every output reads 0 during reset.
  assign fifo_wr_en   = wr_en & ~tb_rst;
  assign fifo_wr_data = tb_rst ? '0 : fft_data;
  assign fifo_rd_en   = rd_grant;

  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    ufl_d     = 1'b0;
    ign_d     = 1'b0;
    pv_d      = 1'b0;
    pd_d      = '0;
    ld_d      = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (line_req) begin
          cnt_d = '0;
          if (line_ok) begin
            r_state_d = R_READ;
          end else begin
            ufl_d     = 1'b1;
            r_state_d = R_FILL;
          end
        end
      end
      R_READ: begin
        ign_d = line_req;
        if (rd_grant) begin
          pv_d  = 1'b1;
          pd_d  = fifo_rd_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            ld_d      = 1'b1;
            cnt_d     = '0;
            r_state_d = R_IDLE;
          end
        end
      end
      R_FILL: begin
        ign_d = line_req;
        pv_d  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          ld_d      = 1'b1;
          cnt_d     = '0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      line_done  <= 1'b0;
      frame_drop <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      pix_valid  <= pv_d;
      pix_data   <= pd_d;
      line_done  <= ld_d;
      frame_drop <= drop_d;
      underflow  <= ufl_d;
    end
  end

  // The level check at frame start should make a full FIFO mid-frame impossible.
  ovf_never_set_a: assert property (@(posedge clk_tb) disable iff (tb_rst) !ovf_q);

`ifdef FFT_FIFO_CTRL_STATS_EN
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      drop_cnt <= '0;
      ufl_cnt  <= '0;
      ign_cnt  <= '0;
    end else begin
      if (drop_d && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (ufl_d && ufl_cnt != 16'hFFFF) ufl_cnt <= ufl_cnt + 16'd1;
      if (ign_d && ign_cnt != 16'hFFFF) ign_cnt <= ign_cnt + 16'd1;
    end
  end
`endif

endmodule
